// File: rtl/countdown_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } cd_state_t;

  localparam int CD_WIDTH_DEFAULT = 4;

endpackage : countdown_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with pause and a one-cycle done pulse on expiry.
// Optional periodic mode: define COUNTDOWN_AUTO_RELOAD_EN to reload from the last loaded value.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Handshake: none; load/start/pause are level inputs sampled on every rising edge,
  // and done is a registered single-cycle strobe with no acknowledge.

  cd_state_t        state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             done_nxt;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload, reload_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) reload <= '0;
    else          reload <= reload_nxt;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_nxt = reload;
`endif
    if (load) begin
      // Load aborts any countdown silently and parks in IDLE.
      count_nxt = load_data;
      state_nxt = IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_nxt = load_data;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && (count != '0)) state_nxt = RUN;
        end
        RUN: begin
          if (pause) begin
            state_nxt = HOLD;
          end else if (count > ONE) begin
            count_nxt = count - ONE;
          end else if (count == ONE) begin
            done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            count_nxt = reload;
`else
            count_nxt = '0;
            state_nxt = IDLE;
`endif
          end
        end
        HOLD: begin
          if (!pause) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_countdown_timer;
  import countdown_pkg::*;

  localparam int W = CD_WIDTH_DEFAULT;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load;
  logic [W-1:0] load_data;
  logic         start;
  logic         pause;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  // Reference model: remaining count, whether a countdown is live, whether it is frozen.
  int unsigned m_count, m_reload;
  bit          m_live, m_frozen, m_done;
  logic [W+1:0] exp_q[$];

  countdown_timer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .start     (start),
    .pause     (pause),
    .count     (count),
    .busy      (busy),
    .done      (done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count  = 0;
    m_reload = 0;
    m_live   = 1'b0;
    m_frozen = 1'b0;
    m_done   = 1'b0;
  endtask

  task automatic model_edge(input bit l, input int unsigned d, input bit s, input bit p);
    logic [W+1:0] e;
    m_done = 1'b0;
    if (l) begin
      m_count  = d % (1 << W);
      m_reload = m_count;
      m_live   = 1'b0;
      m_frozen = 1'b0;
    end else if (!m_live) begin
      if (s && m_count != 0) begin
        m_live   = 1'b1;
        m_frozen = 1'b0;
      end
    end else if (m_frozen) begin
      if (!p) m_frozen = 1'b0;
    end else if (p) begin
      m_frozen = 1'b1;
    end else if (m_count > 1) begin
      m_count = m_count - 1;
    end else if (m_count == 1) begin
      m_done = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      m_count = m_reload;
`else
      m_count = 0;
      m_live  = 1'b0;
`endif
    end
    e = {m_done, m_live, W'(m_count)};
    exp_q.push_back(e);
  endtask

  task automatic compare(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check_val({tag, "_count"}, count, e[W-1:0]);
    check_val({tag, "_busy"},  busy,  e[W]);
    check_val({tag, "_done"},  done,  e[W+1]);
  endtask

  // Driver: apply inputs on the falling edge, step model on the rising edge, sample 1ns later.
  task automatic cycle(input bit l, input int unsigned d, input bit s, input bit p, input string tag);
    @(negedge clk);
    load      = l;
    load_data = W'(d);
    start     = s;
    pause     = p;
    @(posedge clk);
    model_edge(l, d, s, p);
    #1;
    compare(tag);
    if (done) done_cnt++;
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    check_val("async_rst_count", count, 0);
    check_val("async_rst_busy",  busy,  0);
    check_val("async_rst_done",  done,  0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int lat;
    bit got_done;
    reset_n   = 1'b0;
    load      = 1'b0;
    load_data = '0;
    start     = 1'b0;
    pause     = 1'b0;
    model_reset();
    #12;
    check_val("reset_count", count, 0);
    check_val("reset_busy",  busy,  0);
    check_val("reset_done",  done,  0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic countdown from 3: exactly one done pulse.
    done_cnt = 0;
    cycle(1, 3, 0, 0, "basic_load");
    cycle(0, 0, 1, 0, "basic_start");
    check_val("basic_start_count", count, 3);
    repeat (4) cycle(0, 0, 0, 0, "basic_run");
    check_val("basic_done_pulses", done_cnt, 1);

    // Pause for 3 cycles after count reaches 3: done at N + pause_cycles + 1 edges after start.
    cycle(1, 4, 0, 0, "pause_load");
    cycle(0, 0, 1, 0, "pause_start");
    lat = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      cycle(0, 0, 0, (i >= 1 && i <= 3), "pause_run");
      lat++;
      got_done = done;
    end
    check_val("pause_latency", got_done ? lat : 0, 8);

    // Load and start together mid-run: load wins, no done.
    done_cnt = 0;
    cycle(1, 5, 0, 0, "prio_load5");
    cycle(0, 0, 1, 0, "prio_start");
    repeat (3) cycle(0, 0, 0, 0, "prio_run");
    check_val("prio_pre_count", count, 2);
    cycle(1, 9, 1, 0, "prio_load9");
    check_val("prio_count9", count, 9);
    check_val("prio_busy",   busy,  0);
    repeat (2) cycle(0, 0, 0, 0, "prio_idle");
    check_val("prio_no_done", done_cnt, 0);

    // Start with count zero is ignored.
    done_cnt = 0;
    cycle(1, 0, 0, 0, "zero_load");
    repeat (4) cycle(0, 0, 1, 0, "zero_start");
    check_val("zero_busy",    busy,     0);
    check_val("zero_no_done", done_cnt, 0);

    // Asynchronous reset mid-run at count 5: immediate clear, no later done.
    cycle(1, 7, 0, 0, "arst_load");
    cycle(0, 0, 1, 0, "arst_start");
    repeat (2) cycle(0, 0, 0, 0, "arst_run");
    check_val("arst_pre_count", count, 5);
    async_reset_pulse();
    done_cnt = 0;
    repeat (6) cycle(0, 0, 0, 0, "arst_after");
    check_val("arst_no_done", done_cnt, 0);

    // Randomized traffic against the model, with occasional async resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) async_reset_pulse();
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, (1 << W) - 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_countdown_timer
